// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit into the clk domain.
// Latency: 2 falling clk edges from d to q.
// Backpressure: none; free-running sampler.
module sync_2ff #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture on the falling edge; both stages reset to the line's idle value.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      meta <= ResetValue;
      q    <= ResetValue;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: samples each bit mid-period and presents the byte with a framing-error flag.
// Latency: dr rises 3 + BIT_TIME/2 + 9*BIT_TIME clocks after the start-bit falling edge on rx.
// Backpressure: go low acknowledges; frames arriving while a byte awaits acknowledge are dropped.
module uart_receiver #(
  parameter int ClockFrequencyHz = 66_000_000,
  parameter int BaudRate         = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       go,
  output logic [7:0] data,
  output logic       dr,
  output logic       ferr
);

  localparam int BitTime = ClockFrequencyHz / BaudRate;
  localparam int CntW    = $clog2(BitTime);

  // Half a bit from the detected edge lands the start-bit sample near its centre;
  // every later sample is one full bit after the previous one.
  localparam logic [CntW-1:0] HalfLoad = CntW'(BitTime / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(BitTime - 1);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StStartBit   = 3'd1;
  localparam logic [2:0] StDataBits   = 3'd2;
  localparam logic [2:0] StStopBit    = 3'd3;
  localparam logic [2:0] StWaitForGoLow = 3'd4;

  logic            rx_s;
  logic            rx_d;
  logic [2:0]      state;
  logic [CntW-1:0] cnt;
  logic [2:0]      idx;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // One-cycle delayed copy of the synchronized line for falling-edge detection.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_d <= 1'b1;
    end else begin
      rx_d <= rx_s;
    end
  end

  // Frame state machine: start qualification, bit sampling, stop check, acknowledge handshake.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      cnt   <= '0;
      idx   <= '0;
      data  <= '0;
      dr    <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          // Requiring rx_d high keeps a held-low (break) line from retriggering.
          if (go && rx_d && !rx_s) begin
            cnt   <= HalfLoad;
            state <= StStartBit;
          end
        end

        StStartBit: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt   <= FullLoad;
              idx   <= '0;
              state <= StDataBits;
            end else begin
              // Glitch shorter than half a bit: not a real start bit.
              state <= StIdle;
            end
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end

        StDataBits: begin
          if (cnt == '0) begin
            data[idx] <= rx_s;
            cnt       <= FullLoad;
            idx       <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= StStopBit;
            end
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end

        StStopBit: begin
          if (cnt == '0) begin
            dr    <= 1'b1;
            ferr  <= ~rx_s;
            state <= StWaitForGoLow;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end

        StWaitForGoLow: begin
          // Line activity here is ignored; data holds until the next frame writes bit 0.
          if (!go) begin
            dr    <= 1'b0;
            ferr  <= 1'b0;
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 1 MHz / 100 kbaud (10 clocks per bit).
// Latency: drives frames bit-by-bit from the rising edge, samples outputs on rising edges.
// Backpressure: acknowledges each presented byte by pulsing go low.
module tb_uart_receiver;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       go;
  logic [7:0] data;
  logic       dr;
  logic       ferr;

  int n_assert = 0;
  int n_fail   = 0;
  int first_dr;

  uart_receiver #(
    .ClockFrequencyHz(1_000_000),
    .BaudRate        (100_000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .go   (go),
    .data (data),
    .dr   (dr),
    .ferr (ferr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-bit frame, 10 clocks per bit; reports the rising edge (counted from the
  // start-bit edge) at which dr was first seen high, or -1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit drop_go,
                            output int fd);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    fd   = -1;
    for (int i = 0; i < 100; i++) begin
      rx = bits[i / 10];
      if (drop_go && i == 30) go = 1'b0;
      if (drop_go && i == 60) go = 1'b1;
      @(posedge clk);
      if (dr === 1'b1 && fd < 0) fd = i + 1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic ack(input string tag);
    go = 1'b0;
    @(posedge clk);
    check({tag, "_dr_cleared"}, dr, 1'b0);
    check({tag, "_ferr_cleared"}, ferr, 1'b0);
    go = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    go  = 1'b0;
    repeat (3) @(posedge clk);
    check("reset_data", data, 8'h00);
    check("reset_dr", dr, 1'b0);
    check("reset_ferr", ferr, 1'b0);
    rst = 1'b0;
    go  = 1'b1;
    idle(10);

    // Basic byte with valid stop, plus end-to-end latency.
    send_frame(8'h55, 1'b1, 1'b0, first_dr);
    check("b55_dr", dr, 1'b1);
    check("b55_data", data, 8'h55);
    check("b55_ferr", ferr, 1'b0);
    check("b55_latency_in_97_99", (first_dr >= 97 && first_dr <= 99), 1'b1);
    ack("b55");
    check("b55_data_held_after_ack", data, 8'h55);
    idle(5);

    // Short low glitch is rejected, following frame is clean.
    hold_rx(1'b0, 3);
    idle(30);
    check("glitch_no_dr", dr, 1'b0);
    check("glitch_data_unchanged", data, 8'h55);
    send_frame(8'hA5, 1'b1, 1'b0, first_dr);
    check("bA5_dr", dr, 1'b1);
    check("bA5_data", data, 8'hA5);
    check("bA5_ferr", ferr, 1'b0);
    ack("bA5");
    idle(5);

    // Bad stop bit followed by a break; break must not retrigger after ack.
    send_frame(8'h3C, 1'b0, 1'b0, first_dr);
    hold_rx(1'b0, 40);
    check("b3C_dr", dr, 1'b1);
    check("b3C_ferr", ferr, 1'b1);
    check("b3C_data", data, 8'h3C);
    ack("b3C");
    hold_rx(1'b0, 120);
    check("break_no_retrigger_dr", dr, 1'b0);
    check("break_data_held", data, 8'h3C);
    idle(20);
    send_frame(8'h96, 1'b1, 1'b0, first_dr);
    check("b96_after_break_data", data, 8'h96);
    check("b96_after_break_ferr", ferr, 1'b0);
    ack("b96");
    idle(5);

    // Back-to-back frames with ack withheld: the second is dropped.
    send_frame(8'h01, 1'b1, 1'b0, first_dr);
    check("b01_data", data, 8'h01);
    send_frame(8'h80, 1'b1, 1'b0, first_dr);
    check("overrun_dr_still_high", dr, 1'b1);
    check("overrun_data_kept", data, 8'h01);
    check("overrun_ferr", ferr, 1'b0);
    ack("overrun");
    idle(5);
    send_frame(8'hFF, 1'b1, 1'b0, first_dr);
    check("bFF_data", data, 8'hFF);
    check("bFF_dr", dr, 1'b1);
    ack("bFF");
    idle(5);

    // Reset during data bit 4 discards the partial byte.
    hold_rx(1'b0, 10);
    hold_rx(1'b1, 10);
    hold_rx(1'b0, 10);
    hold_rx(1'b0, 10);
    hold_rx(1'b1, 10);
    hold_rx(1'b1, 5);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_data", data, 8'h00);
    check("midrst_dr", dr, 1'b0);
    check("midrst_ferr", ferr, 1'b0);
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    idle(60);
    check("postrst_no_dr", dr, 1'b0);
    check("postrst_data", data, 8'h00);

    // go dropped mid-frame must not abort reception.
    send_frame(8'h42, 1'b1, 1'b1, first_dr);
    check("b42_dr", dr, 1'b1);
    check("b42_data", data, 8'h42);
    check("b42_ferr", ferr, 1'b0);
    ack("b42");
    idle(5);

    // Loopback sweep over every byte value.
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1, 1'b0, first_dr);
      check("sweep_data", data, 32'(v));
      check("sweep_ferr", ferr, 1'b0);
      go = 1'b0;
      @(posedge clk);
      go = 1'b1;
      idle(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
